dcache_assoc: RTL
=================

Name: dcache_assoc

Overview:
Parametrised, fully associative, write-back, write-allocate data cache between the CPU core load/store port and the memory controller. Generalises the 4-line single-word cache to LINENUM lines with configurable address, data and TTL widths. Adds the following:
- dirty tracking with victim write-back
- a central request FSM
- misalignment reporting
- a whole-cache flush mode

Each line holds one DATABITS word tagged by its word address.

Parameters:
ADDRBITS, 32, byte address width
DATABITS, 32, data word width; fixed at 32 (byte-enable decode is 4 lanes)
LINENUM, 4, number of cache lines (2..16)
TTLBITS, 8, width of per-line age counter (saturating)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
dcache_addr  in  ADDRBITS  byte address, held stable until dcache_valid
dcache_datain  in  DATABITS  store data, right-aligned (bits [7:0] for bytes)
dcache_rdreq  in  1  load request
dcache_wrreq  in  1  store request
dcache_wordlen  in  2  0=8 bit, 1=16 bit, 2=32 bit
dcache_flush  in  1  write back all dirty lines and invalidate all lines
dcache_dataout  out  DATABITS  load data, shifted to bit 0, zero-extended
dcache_valid  out  1  one-cycle completion pulse
dcache_misalign  out  1  qualifies dcache_valid: access rejected
dcache_busy  out  1  high whenever FSM is not IDLE
mem_addr  out  ADDRBITS  word-aligned address ([1:0]=0)
mem_in  out  DATABITS  write-back data
mem_rdreq  out  1  fill request, held until mem_valid
mem_wrreq  out  1  write-back request, held until mem_valid
mem_out  in  DATABITS  fill data, valid with mem_valid
mem_valid  in  1  memory completion strobe

Behaviour:
- Reset (async): all outputs 0; all lines invalid, clean, TTL=0; FSM=IDLE. Reset mid-transaction drops mem_rdreq/mem_wrreq immediately and loses pending data.
- Byte enables are decoded from {addr[1:0],wordlen}:
  - 8-bit: lanes 0..3 per addr[1:0]
  - 16-bit: addr 0 -> 0011, addr 2 -> 1100
  - 32-bit: addr 0 -> 1111
  - any other combination is misaligned.
- FSM states: IDLE, HIT, WB, FILL, RESP, FLUSH.
- IDLE priority order: dcache_flush > dcache_wrreq > dcache_rdreq (simultaneous rd+wr = write).
  - Misaligned request: next cycle dcache_valid=1, dcache_misalign=1, dataout=0; no state or TTL change.
  - Hit (valid line with tag == addr[ADDRBITS-1:2]): -> HIT. dcache_valid pulses the cycle after the request is sampled (latency 1). Store merges the enabled lanes and sets dirty.
  - Miss: select victim. If victim is valid and dirty -> WB, else -> FILL.
- Victim selection: lowest-index invalid line; otherwise the line with the highest TTL; on a tie, the lowest index wins.
- WB: mem_wrreq=1, mem_addr={victim tag,2'b00}, mem_in=victim data. Held until mem_valid, then -> FILL.
- FILL: mem_rdreq=1, mem_addr={req word addr,2'b00}. Held until mem_valid; then write mem_out into the victim, tag it, valid=1, dirty=0, -> RESP.
- RESP: complete as for a hit (store merges lanes and sets dirty); dcache_valid pulse; -> IDLE. Miss latency = 2 + memory cycles.
- mem_rdreq and mem_wrreq are never high together. mem_valid outside WB/FILL is ignored.
- TTL update, on every completed non-misaligned access:
  - accessed line TTL=0
  - every other valid line TTL+1, saturating at 2^TTLBITS-1
  - invalid lines stay 0.
- FLUSH: scan index 0..LINENUM-1. Each valid dirty line performs a WB handshake; every line is invalidated, cleared and its TTL zeroed. Completion gives one dcache_valid pulse (misalign=0), then -> IDLE. A request arriving during a flush waits until IDLE.
- Requests are sampled only in IDLE. The core holds request inputs until dcache_valid, and may issue the next request in the cycle after the pulse.
- dcache_dataout is valid only while dcache_valid=1 and is 0 otherwise.

Test Plan:
- Cold read 0x100, mem returns 0xDEADBEEF after 3 cycles -> mem_rdreq addr 0x100 held 3 cycles; valid pulse with dataout 0xDEADBEEF; re-read 0x100 -> valid 1 cycle later, no mem activity.
- Byte store 0xAA to 0x102 on cached 0x11223344, then read word -> 0x11AA3344; line dirty; no memory write.
- Fill 4 lines, touch lines in order 0,1,2,3 then miss to a new address -> line 0 evicted. If dirty, mem_wrreq with its address and data precedes mem_rdreq.
- Read halfword at 0x101 and word at 0x102 -> valid+misalign each, dataout 0, no mem requests, TTLs unchanged.
- Two dirty lines and two clean lines, assert flush -> exactly two mem_wrreq handshakes in index order, one valid pulse, then a re-read of any address misses.
- Assert reset_n low during FILL -> mem_rdreq drops at once; after release, the previous hit address misses.

Source files
------------

// File: rtl/dcache_assoc_if.sv
// dcache_assoc_if: core load/store port and memory-controller port of dcache_assoc.
interface dcache_assoc_if #(
   parameter int ADDRBITS = 32,
   parameter int DATABITS = 32
) ();
   logic [ADDRBITS-1:0] dcache_addr;
   logic [DATABITS-1:0] dcache_datain;
   logic dcache_rdreq;
   logic dcache_wrreq;
   logic [1:0] dcache_wordlen;
   logic dcache_flush;
   logic [DATABITS-1:0] dcache_dataout;
   logic dcache_valid;
   logic dcache_misalign;
   logic dcache_busy;
   logic [ADDRBITS-1:0] mem_addr;
   logic [DATABITS-1:0] mem_in;
   logic mem_rdreq;
   logic mem_wrreq;
   logic [DATABITS-1:0] mem_out;
   logic mem_valid;
   modport slave (
      input dcache_addr, dcache_datain, dcache_rdreq, dcache_wrreq, dcache_wordlen, dcache_flush,
      input mem_out, mem_valid,
      output dcache_dataout, dcache_valid, dcache_misalign, dcache_busy,
      output mem_addr, mem_in, mem_rdreq, mem_wrreq
   );
   modport master (
      output dcache_addr, dcache_datain, dcache_rdreq, dcache_wrreq, dcache_wordlen, dcache_flush,
      output mem_out, mem_valid,
      input dcache_dataout, dcache_valid, dcache_misalign, dcache_busy,
      input mem_addr, mem_in, mem_rdreq, mem_wrreq
   );
endinterface

// File: rtl/dcache_assoc.sv
// dcache_assoc: fully associative write-back, write-allocate data cache with TTL-based
// victim selection, misalignment rejection and whole-cache flush.
module dcache_assoc #(
   parameter int ADDRBITS = 32,
   parameter int DATABITS = 32,
   parameter int LINENUM  = 4,
   parameter int TTLBITS  = 8
) (
   input logic clk,
   input logic reset_n,
   dcache_assoc_if.slave bus_io
);
   localparam int TW = ADDRBITS - 2;
   localparam int IW = $clog2(LINENUM);
   localparam logic [2:0] IDLE = 3'd0, HIT = 3'd1, WB = 3'd2, FILL = 3'd3, RESP = 3'd4, FLUSH = 3'd5;

   logic [2:0] state_q, state_d;
   logic [LINENUM-1:0] valid_q, valid_d, dirty_q, dirty_d;
   logic [TW-1:0] tag_q [LINENUM];
   logic [TW-1:0] tag_d [LINENUM];
   logic [DATABITS-1:0] data_q [LINENUM];
   logic [DATABITS-1:0] data_d [LINENUM];
   logic [TTLBITS-1:0] ttl_q [LINENUM];
   logic [TTLBITS-1:0] ttl_d [LINENUM];
   // victim line during a miss, scan pointer during a flush
   logic [IW-1:0] idx_q, idx_d;
   logic rsp_valid_q, rsp_valid_d, rsp_mis_q, rsp_mis_d;
   logic [DATABITS-1:0] rsp_data_q, rsp_data_d;

   logic [TW-1:0] req_tag;
   logic [1:0] off;
   logic [3:0] be;
   logic [DATABITS-1:0] mask, wdata;
   logic hit, do_acc, rdreq, wrreq;
   logic [IW-1:0] hit_idx, vic_idx, acc;

   assign req_tag = bus_io.dcache_addr[ADDRBITS-1:2];
   assign off = bus_io.dcache_addr[1:0];
   assign be = bus_io.dcache_wordlen == 2'd0 ? 4'b0001 << off :
               bus_io.dcache_wordlen == 2'd1 && !off[0] ? (off[1] ? 4'b1100 : 4'b0011) :
               bus_io.dcache_wordlen == 2'd2 && off == 2'd0 ? 4'b1111 : 4'b0000;
   assign mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign wdata = bus_io.dcache_datain << {off, 3'b000};
   assign acc = state_q == RESP ? idx_q : hit_idx;

   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      vic_idx = '0;
      for (int i = LINENUM - 1; i >= 0; i--)
         if (valid_q[i] && tag_q[i] == req_tag) begin
            hit = 1'b1;
            hit_idx = IW'(i);
         end
      // oldest line wins, strict compare keeps the lowest index on ties; any invalid line overrides
      for (int i = 1; i < LINENUM; i++)
         if (ttl_q[i] > ttl_q[vic_idx]) vic_idx = IW'(i);
      for (int i = LINENUM - 1; i >= 0; i--)
         if (!valid_q[i]) vic_idx = IW'(i);
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d = tag_q;
      data_d = data_q;
      ttl_d = ttl_q;
      idx_d = idx_q;
      rsp_valid_d = 1'b0;
      rsp_mis_d = 1'b0;
      rsp_data_d = '0;
      do_acc = 1'b0;
      case (state_q)
         IDLE:
            if (bus_io.dcache_flush) begin
               state_d = FLUSH;
               idx_d = '0;
            end else if (bus_io.dcache_wrreq || bus_io.dcache_rdreq) begin
               if (be == 4'b0000) begin
                  rsp_valid_d = 1'b1;
                  rsp_mis_d = 1'b1;
                  state_d = HIT;
               end else if (hit) begin
                  do_acc = 1'b1;
                  state_d = HIT;
               end else begin
                  idx_d = vic_idx;
                  state_d = valid_q[vic_idx] && dirty_q[vic_idx] ? WB : FILL;
               end
            end
         HIT: state_d = IDLE;
         WB: if (bus_io.mem_valid) state_d = FILL;
         FILL:
            if (bus_io.mem_valid) begin
               data_d[idx_q] = bus_io.mem_out;
               tag_d[idx_q] = req_tag;
               valid_d[idx_q] = 1'b1;
               dirty_d[idx_q] = 1'b0;
               state_d = RESP;
            end
         RESP: begin
            do_acc = 1'b1;
            state_d = HIT;
         end
         FLUSH:
            if (!(valid_q[idx_q] && dirty_q[idx_q]) || bus_io.mem_valid) begin
               valid_d[idx_q] = 1'b0;
               dirty_d[idx_q] = 1'b0;
               tag_d[idx_q] = '0;
               data_d[idx_q] = '0;
               ttl_d[idx_q] = '0;
               rsp_valid_d = idx_q == IW'(LINENUM - 1);
               state_d = idx_q == IW'(LINENUM - 1) ? HIT : FLUSH;
               idx_d = idx_q + 1'b1;
            end
         default: state_d = IDLE;
      endcase
      if (do_acc) begin
         for (int j = 0; j < LINENUM; j++)
            ttl_d[j] = IW'(j) == acc ? '0 : valid_q[j] && ttl_q[j] != '1 ? ttl_q[j] + 1'b1 : ttl_q[j];
         rsp_valid_d = 1'b1;
         rsp_data_d = bus_io.dcache_wrreq ? '0 : (data_q[acc] & mask) >> {off, 3'b000};
         if (bus_io.dcache_wrreq) begin
            data_d[acc] = (data_q[acc] & ~mask) | (wdata & mask);
            dirty_d[acc] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         tag_q <= '{default: '0};
         data_q <= '{default: '0};
         ttl_q <= '{default: '0};
         idx_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_mis_q <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         tag_q <= tag_d;
         data_q <= data_d;
         ttl_q <= ttl_d;
         idx_q <= idx_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_mis_q <= rsp_mis_d;
         rsp_data_q <= rsp_data_d;
      end

   assign rdreq = state_q == FILL;
   assign wrreq = state_q == WB || (state_q == FLUSH && valid_q[idx_q] && dirty_q[idx_q]);
   assign bus_io.mem_rdreq = rdreq;
   assign bus_io.mem_wrreq = wrreq;
   assign bus_io.mem_addr = rdreq ? {req_tag, 2'b00} : wrreq ? {tag_q[idx_q], 2'b00} : '0;
   assign bus_io.mem_in = wrreq ? data_q[idx_q] : '0;
   assign bus_io.dcache_valid = rsp_valid_q;
   assign bus_io.dcache_misalign = rsp_mis_q;
   assign bus_io.dcache_dataout = rsp_data_q;
   assign bus_io.dcache_busy = state_q != IDLE;
endmodule
